// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: channel indices,
// per-channel state encoding and default timing.
package button_pkg;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;
  localparam int BTN_C = 4;

  localparam int NBTN_DEF       = BTN_C + 1;
  localparam int DB_CYCLES_DEF  = 1_000_000;   // 10 ms at 100 MHz
  localparam int RPT_DELAY_DEF  = 50_000_000;
  localparam int RPT_PERIOD_DEF = 10_000_000;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Pad-to-core button bundle: raw pad levels in, conditioned level/pulses out.
interface button_conditioner_if
  import button_pkg::*;
#(
  parameter int NBTN = NBTN_DEF
);
  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] level;
  logic [NBTN-1:0] down;
  logic [NBTN-1:0] up;
  logic [NBTN-1:0] rpt;

  modport master (output raw, input level, down, up, rpt);
  modport slave  (input raw, output level, down, up, rpt);
endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM with stable-time
// counter, and hold-time counter producing auto-repeat pulses.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_down,
  output logic o_up,
  output logic o_rpt
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam int RW = cnt_width(max_int(RPT_DELAY, RPT_PERIOD));
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST  = RW'(RPT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [RW-1:0] RCNT_ZERO = {RW{1'b0}};

  logic          r_sync1, r_sync2;
  btn_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [RW-1:0] r_rcnt, w_rcnt_nxt;
  logic          r_first, w_first_nxt;
  logic          r_level, w_level_nxt;
  logic          r_down, w_down_nxt;
  logic          r_up, w_up_nxt;
  logic          r_rpt, w_rpt_nxt;
  logic          w_s;
  logic [RW-1:0] w_rpt_last;

  assign w_s        = r_sync2;
  assign w_rpt_last = r_first ? RD_LAST : RP_LAST;

  // Pad synchroniser; the raw pad is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_rcnt  <= RCNT_ZERO;
      r_first <= 1'b0;
      r_level <= 1'b0;
      r_down  <= 1'b0;
      r_up    <= 1'b0;
      r_rpt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_first <= w_first_nxt;
      r_level <= w_level_nxt;
      r_down  <= w_down_nxt;
      r_up    <= w_up_nxt;
      r_rpt   <= w_rpt_nxt;
    end
  end

  // Next-state logic; pulses default low so each lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rcnt_nxt  = r_rcnt;
    w_first_nxt = r_first;
    w_level_nxt = r_level;
    w_down_nxt  = 1'b0;
    w_up_nxt    = 1'b0;
    w_rpt_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_s) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = ST_HELD;
          w_level_nxt = 1'b1;
          w_down_nxt  = 1'b1;
          w_rcnt_nxt  = RCNT_ZERO;
          w_first_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1'b1);
        end
      end
      ST_HELD: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_rcnt == w_rpt_last) begin
          w_rpt_nxt   = 1'b1;
          w_rcnt_nxt  = RCNT_ZERO;
          w_first_nxt = 1'b0;
        end else begin
          w_rcnt_nxt = r_rcnt + RW'(1'b1);
        end
      end
      ST_RELEASE_WAIT: begin
        // rcnt is left untouched here so a bounce resumes the repeat timing.
        if (w_s) begin
          w_state_nxt = ST_HELD;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = ST_IDLE;
          w_level_nxt = 1'b0;
          w_up_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1'b1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_level_nxt = 1'b0;
        w_cnt_nxt   = CNT_ZERO;
        w_rcnt_nxt  = RCNT_ZERO;
        w_first_nxt = 1'b0;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_down  = r_down;
  assign o_up    = r_up;
  assign o_rpt   = r_rpt;

endmodule

// File: rtl/button_conditioner.sv
// Five-channel (by default) button front end: one independent debounce
// channel per pad, outputs concatenated onto the core-facing bundle.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NBTN       = NBTN_DEF,
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  logic [NBTN-1:0] w_level;
  logic [NBTN-1:0] w_down;
  logic [NBTN-1:0] w_up;
  logic [NBTN-1:0] w_rpt;

  for (genvar g = 0; g < NBTN; g++) begin : g_chan
    debounce_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (bus.raw[g]),
      .o_level (w_level[g]),
      .o_down  (w_down[g]),
      .o_up    (w_up[g]),
      .o_rpt   (w_rpt[g])
    );
  end

  assign bus.level = w_level;
  assign bus.down  = w_down;
  assign bus.up    = w_up;
  assign bus.rpt   = w_rpt;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed table, hand-written corner
// sequences and randomized bouncing pads against a behavioural model.
module tb_button_conditioner;
  localparam int NB = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_n = 0;

  button_conditioner_if #(.NBTN(NB)) bus ();

  button_conditioner #(
    .NBTN(NB), .DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: a pad's level flips once it has disagreed with the
  // current level for more than DB consecutive synchronised samples; repeat
  // pulses fall on held-sample counts RD, RD+RP, RD+2RP, ...
  logic [NB-1:0] m_d1, m_d2, m_level, m_down, m_up, m_rpt;
  int            m_run  [NB];
  int            m_hold [NB];

  task automatic model_step(input logic [NB-1:0] r, input logic rs);
    logic s;
    m_down = '0; m_up = '0; m_rpt = '0;
    if (rs) begin
      m_d1 = '0; m_d2 = '0; m_level = '0;
      for (int c = 0; c < NB; c++) begin m_run[c] = 0; m_hold[c] = 0; end
    end else begin
      for (int c = 0; c < NB; c++) begin
        s = m_d2[c];
        if (s != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] > DB) begin
            m_level[c] = s;
            m_run[c]   = 0;
            if (s) begin m_down[c] = 1'b1; m_hold[c] = 0; end
            else m_up[c] = 1'b1;
          end
        end else begin
          if (m_level[c] && m_run[c] == 0) begin
            m_hold[c]++;
            if (m_hold[c] == RD || (m_hold[c] > RD && (m_hold[c] - RD) % RP == 0))
              m_rpt[c] = 1'b1;
          end
          m_run[c] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = r;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc_n, act, exp);
    end
  endtask

  // One clock: drive at negedge, step model at posedge, compare 1 time unit later.
  task automatic cyc(input logic [NB-1:0] r, input logic rs);
    @(negedge clk);
    bus.raw = r;
    rst     = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
    cyc_n++;
    chk("model", {12'd0, bus.level, bus.down, bus.up, bus.rpt},
        {12'd0, m_level, m_down, m_up, m_rpt});
  endtask

  task automatic do_reset();
    cyc('0, 1'b1);
    cyc('0, 1'b1);
    chk("reset_out", {12'd0, bus.level, bus.down, bus.up, bus.rpt}, 32'd0);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
  endtask

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] level;
    logic [NB-1:0] down;
    logic [NB-1:0] up;
    logic [NB-1:0] rpt;
  } vec_t;

  vec_t          tbl [10];
  logic [NB-1:0] rnd_raw;
  logic          rnd_rst;
  int            dur [NB];
  logic          exp_bit;

  initial begin
    bus.raw = '0;
    m_d1 = '0; m_d2 = '0; m_level = '0; m_down = '0; m_up = '0; m_rpt = '0;
    for (int c = 0; c < NB; c++) begin m_run[c] = 0; m_hold[c] = 0; dur[c] = 0; end

    // Clean press on L with a 3-cycle glitch on U alongside it.
    for (int i = 0; i < 10; i++) begin
      tbl[i].raw   = (i < 3) ? 5'b00101 : 5'b00001;
      tbl[i].level = (i >= 6) ? 5'b00001 : 5'b00000;
      tbl[i].down  = (i == 6) ? 5'b00001 : 5'b00000;
      tbl[i].up    = 5'b00000;
      tbl[i].rpt   = 5'b00000;
    end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].raw, 1'b0);
      chk("tbl_level", {27'd0, bus.level}, {27'd0, tbl[i].level});
      chk("tbl_down",  {27'd0, bus.down},  {27'd0, tbl[i].down});
      chk("tbl_up",    {27'd0, bus.up},    {27'd0, tbl[i].up});
      chk("tbl_rpt",   {27'd0, bus.rpt},   {27'd0, tbl[i].rpt});
    end

    // Hold C: down at k=6, repeats at down+10, then every 3 cycles.
    do_reset();
    for (int k = 0; k <= 36; k++) begin
      cyc(5'b10000, 1'b0);
      chk("hold_down", {31'd0, bus.down[4]}, {31'd0, (k == 6)});
      exp_bit = (k == 16 || k == 19 || k == 22 || k == 25 ||
                 k == 28 || k == 31 || k == 34);
      chk("hold_rpt", {31'd0, bus.rpt[4]}, {31'd0, exp_bit});
    end
    chk("hold_others", {28'd0, bus.level[3:0]}, 32'd0);

    // Release of R with a one-cycle bounce; single up 6 edges after final fall.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(5'b00010, 1'b0);
    chk("rel_held", {27'd0, bus.level}, 32'd2);
    cyc(5'b00000, 1'b0);
    cyc(5'b00000, 1'b0);
    cyc(5'b00010, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(5'b00000, 1'b0);
      chk("rel_up",  {27'd0, bus.up},  (k == 6) ? 32'd2 : 32'd0);
      chk("rel_rpt", {27'd0, bus.rpt}, 32'd0);
      chk("rel_level", {31'd0, bus.level[1]}, {31'd0, (k < 6)});
    end

    // Reset while D is in its debounce wait and L is already held.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(5'b00001, 1'b0);
    for (int i = 0; i < 4; i++) cyc(5'b01001, 1'b0);
    chk("rstmid_pre", {27'd0, bus.level}, 32'd1);
    cyc(5'b01001, 1'b1);
    chk("rstmid_zero", {12'd0, bus.level, bus.down, bus.up, bus.rpt}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      cyc(5'b01001, 1'b0);
      chk("rstmid_down", {27'd0, bus.down}, (k == 6) ? 32'h9 : 32'd0);
    end

    // All five pads rise on the same edge.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(5'b11111, 1'b0);
      chk("simul_down", {27'd0, bus.down}, (k == 6) ? 32'h1f : 32'd0);
    end

    // Randomized bouncing pads with occasional resets, model-checked.
    do_reset();
    rnd_raw = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NB; c++) begin
        if (dur[c] == 0) begin
          rnd_raw[c] = ~rnd_raw[c];
          dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30)
                                               : $urandom_range(1, 6);
        end else begin
          dur[c]--;
        end
      end
      rnd_rst = ($urandom_range(0, 399) == 0);
      cyc(rnd_raw, rnd_rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
